// File: rtl/vga_timing_gen.sv
// VGA raster timing and test-pattern generator.
// Counters, sync, data-enable, coordinates and pattern colour are decoded and registered together.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 7,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11,
  parameter int COLOR_W  = 4,
  parameter int CHK_LOG2 = 6
) (
  input  logic                 dclk,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C     = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C     = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C    = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_ACT_LAST_C = CNT_W'(H_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST_C = CNT_W'(V_START + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] X_LAST_C     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST_C     = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_W_C      = CNT_W'(H_ACTIVE / 8);
  localparam logic [CNT_W-1:0] BAR_MAX_C    = CNT_W'(7);

  // Counters must hold the last position of each axis; bars need a nonzero width.
  if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_cnt_w_check
    $fatal(1, "vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (H_ACTIVE < 8 || CHK_LOG2 >= CNT_W) begin : g_geom_check
    $fatal(1, "vga_timing_gen: H_ACTIVE must be >= 8 and CHK_LOG2 < CNT_W");
  end

  logic [CNT_W-1:0]   hc, vc;
  logic [1:0]         mode_q;
  logic               hs_on, vs_on, de_c, first_c, frame_end;
  logic [CNT_W-1:0]   x_c, y_c, bar_raw;
  logic [2:0]         bar_idx, mask;
  logic [3*COLOR_W-1:0] rgb_c;

  always_comb begin
    hs_on     = (hc < H_SYNC_C);
    vs_on     = (vc < V_SYNC_C);
    de_c      = (hc >= H_START_C) && (hc <= H_ACT_LAST_C) &&
                (vc >= V_START_C) && (vc <= V_ACT_LAST_C);
    x_c       = de_c ? (hc - H_START_C) : '0;
    y_c       = de_c ? (vc - V_START_C) : '0;
    first_c   = de_c && (hc == H_START_C) && (vc == V_START_C);
    frame_end = (hc == H_LAST_C) && (vc == V_LAST_C);

    bar_raw = x_c / BAR_W_C;
    bar_idx = (bar_raw > BAR_MAX_C) ? 3'd7 : bar_raw[2:0];

    // mask is {R,G,B} fully on/off for the three fixed-colour patterns
    mask = 3'b000;
    case (mode_q)
      2'd0: begin
        case (bar_idx)
          3'd0:    mask = 3'b111;
          3'd1:    mask = 3'b110;
          3'd2:    mask = 3'b011;
          3'd3:    mask = 3'b010;
          3'd4:    mask = 3'b101;
          3'd5:    mask = 3'b100;
          3'd6:    mask = 3'b001;
          default: mask = 3'b000;
        endcase
      end
      2'd1:    mask = (x_c[CHK_LOG2] ^ y_c[CHK_LOG2]) ? 3'b000 : 3'b111;
      2'd3:    mask = ((x_c == '0) || (x_c == X_LAST_C) || (y_c == '0) || (y_c == Y_LAST_C))
                      ? 3'b111 : 3'b000;
      default: mask = 3'b000;
    endcase

    if (!de_c)
      rgb_c = '0;
    else if (mode_q == 2'd2)
      rgb_c = solid_rgb;
    else
      rgb_c = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      mode_q      <= 2'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      if (hc == H_LAST_C) begin
        hc <= '0;
        vc <= (vc == V_LAST_C) ? '0 : vc + CNT_W'(1);
      end else begin
        hc <= hc + CNT_W'(1);
      end
      // New pattern takes effect from the first pixel of the next frame
      if (frame_end)
        mode_q <= mode;

      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      de          <= de_c;
      x           <= x_c;
      y           <= y_c;
      red         <= rgb_c[3*COLOR_W-1 -: COLOR_W];
      green       <= rgb_c[2*COLOR_W-1 -: COLOR_W];
      blue        <= rgb_c[COLOR_W-1 -: COLOR_W];
      frame_start <= first_c;
      if (first_c)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (60 x 29 totals, 40 x 20 visible).
// pos = cycles since reset release; outputs observed at pos reflect raster position pos.
module tb_vga_timing_gen;

  localparam int HT = 60;
  localparam int FT = 60 * 29;

  logic        dclk = 1'b0;
  logic        clr;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  x, y;
  logic [3:0]  red, green, blue;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .CNT_W(8), .COLOR_W(4), .CHK_LOG2(2)
  ) dut (
    .dclk(dclk), .clr(clr), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int p);
    if (p < pos) begin
      n_cmp++;
      n_err++;
      $error("FAIL step_to: observed pos %0d expected <= %0d", pos, p);
    end
    while (pos < p) begin
      @(posedge dclk);
      #1;
      pos++;
    end
  endtask

  task automatic restart();
    @(negedge dclk);
    clr = 1'b0;
    @(posedge dclk);
    #1;
    pos = 0;
  endtask

  // pixel position of visible (px,py) in frame f
  function automatic int at(input int f, input int px, input int py);
    return f * FT + (7 + py) * HT + 16 + px;
  endfunction

  initial begin
    clr = 1'b1;
    mode = 2'd0;
    solid_rgb = 12'h5A3;
    repeat (3) @(posedge dclk);
    #1;
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b0);
    chk("rst_de", de, 1'b0);
    chk("rst_xy", {x, y}, 16'h0);
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_fs_fc", {frame_start, frame_cnt}, 17'h0);

    restart();
    $display("step: timing after reset release");
    chk("p0_hsync", hsync, 1'b0);
    chk("p0_vsync", vsync, 1'b1);
    step_to(5);   chk("p5_hsync", hsync, 1'b0);
    step_to(6);   chk("p6_hsync", hsync, 1'b1);
    step_to(59);  chk("p59_hsync", hsync, 1'b1);
    step_to(60);  chk("p60_hsync", hsync, 1'b0);
    step_to(179); chk("p179_vsync", vsync, 1'b1);
    step_to(180); chk("p180_vsync", vsync, 1'b0);
    step_to(435); chk("pre_de", de, 1'b0);

    $display("step: frame 0 colour bars");
    step_to(at(0, 0, 0));
    chk("f0_de", de, 1'b1);
    chk("f0_xy", {x, y}, 16'h0000);
    chk("f0_fs", frame_start, 1'b1);
    chk("f0_fc", frame_cnt, 16'd1);
    chk("bar_x0", {red, green, blue}, 12'hFFF);
    step_to(at(0, 1, 0)); chk("f0_fs_low", frame_start, 1'b0);
    step_to(at(0, 4, 0)); chk("bar_x4", {red, green, blue}, 12'hFFF);
    step_to(at(0, 5, 0)); chk("bar_x5", {red, green, blue}, 12'hFF0);
    step_to(at(0, 12, 0)); chk("bar_x12", {red, green, blue}, 12'h0FF);
    step_to(at(0, 30, 0)); chk("bar_x30", {red, green, blue}, 12'h00F);
    step_to(at(0, 35, 0)); chk("bar_x35", {de, red, green, blue}, 13'h1000);
    step_to(at(0, 39, 0)); chk("bar_x39_xy", {x, y}, 16'h2700);
    step_to(at(0, 39, 0) + 1);
    chk("blank_de", de, 1'b0);
    chk("blank_x", x, 8'd0);
    chk("blank_rgb", {red, green, blue}, 12'h000);
    step_to(at(0, 0, 1)); chk("f0_y1_fs", {frame_start, y}, 9'h001);

    mode = 2'd1;
    step_to(at(0, 7, 10)); chk("f0_still_bars", {red, green, blue}, 12'hFF0);

    $display("step: frame 1 checkerboard");
    step_to(FT); chk("f1_vsync", vsync, 1'b1);
    step_to(at(1, 0, 0)); chk("f1_fs_fc", {frame_start, frame_cnt}, 17'h10002);
    step_to(at(1, 3, 0)); chk("chk_3_0", {red, green, blue}, 12'hFFF);
    step_to(at(1, 4, 0)); chk("chk_4_0", {red, green, blue}, 12'h000);
    step_to(at(1, 4, 4)); chk("chk_4_4", {red, green, blue}, 12'hFFF);
    mode = 2'd2;
    step_to(at(1, 0, 10)); chk("f1_still_chk_0_10", {red, green, blue}, 12'hFFF);
    step_to(at(1, 4, 10)); chk("f1_still_chk_4_10", {red, green, blue}, 12'h000);

    $display("step: frame 2 solid");
    step_to(at(2, 0, 0)); chk("solid_0_0", {red, green, blue}, 12'h5A3);
    step_to(at(2, 10, 5) - 1);
    solid_rgb = 12'h123;
    step_to(at(2, 10, 5)); chk("solid_live", {red, green, blue}, 12'h123);
    step_to(at(2, 39, 19)); chk("solid_last", {red, green, blue}, 12'h123);
    mode = 2'd3;

    $display("step: frame 3 border");
    step_to(at(3, 0, 0));
    chk("bord_0_0", {red, green, blue}, 12'hFFF);
    chk("f3_fc", frame_cnt, 16'd4);
    step_to(at(3, 1, 1)); chk("bord_1_1", {red, green, blue}, 12'h000);
    step_to(at(3, 38, 10)); chk("bord_38_10", {red, green, blue}, 12'h000);
    step_to(at(3, 39, 10)); chk("bord_39_10", {red, green, blue}, 12'hFFF);
    step_to(at(3, 5, 19)); chk("bord_5_19", {red, green, blue}, 12'hFFF);

    $display("step: clr mid-frame");
    step_to(4 * FT + 15 * HT + 30);
    chk("pre_clr_de", de, 1'b1);
    chk("pre_clr_fc", frame_cnt, 16'd5);
    clr = 1'b1;
    #1;
    chk("clr_hsync", hsync, 1'b1);
    chk("clr_vsync", vsync, 1'b0);
    chk("clr_de_xy", {de, x, y}, 17'h0);
    chk("clr_rgb", {red, green, blue}, 12'h000);
    chk("clr_fs_fc", {frame_start, frame_cnt}, 17'h0);
    @(posedge dclk);
    restart();
    chk("rel_sync", {hsync, vsync}, 2'b01);
    chk("rel_fc", frame_cnt, 16'd0);
    step_to(at(0, 0, 0));
    chk("rel_fs_fc", {frame_start, frame_cnt}, 17'h10001);
    chk("rel_bars", {red, green, blue}, 12'hFFF);
    step_to(at(0, 1, 1)); chk("rel_bars_1_1", {red, green, blue}, 12'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
